stream_out_packer: RTL and testbench

- Downstream neighbour of the display tiler; consumes its per-pixel outputs (pixel, first, lastx, lasty).
- Drives the tiler's ready/valid_int pair and converts each grayscale pixel into an AXI4-Stream video beat (tuser = SOF, tlast = EOL) for the VDMA/video-out IP.
- Absorbs downstream backpressure with a 2-entry skid buffer.
- Gates streaming on frame boundaries, counts frames, and flags line-length errors.

---
 rtl/stream_out_packer.sv | 162 ++++++++++++++++
 tb/tb_stream_out_packer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_out_packer.sv
// Packs tiler grayscale pixels into AXI4-Stream video beats behind a 2-entry skid buffer.
// Streaming starts and stops only on frame boundaries; also counts frames and flags bad line lengths.
module stream_out_packer #(
  parameter int unsigned X_SIZE   = 640,
  parameter int unsigned PIX_BITS = 8,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                  out_stream_aclk,
  input  logic                  periph_resetn,
  input  logic                  enable,
  input  logic [PIX_BITS-1:0]   in_pixel,
  input  logic                  in_first,
  input  logic                  in_lastx,
  input  logic                  in_lasty,
  output logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_W-1:0]     out_stream_tdata,
  output logic [DATA_W/8-1:0]   out_stream_tkeep,
  output logic                  out_stream_tuser,
  output logic                  out_stream_tlast,
  output logic                  out_stream_tvalid,
  input  logic                  out_stream_tready,
  output logic [15:0]           frame_count,
  output logic                  line_len_err,
  output logic                  streaming
);

  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned COL_W  = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int unsigned FC_W   = 16;
  localparam int unsigned REP    = (8 + PIX_BITS - 1) / PIX_BITS;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(X_SIZE - 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              user;
    logic              last;
  } beat_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  state_e            state_q, state_d;
  beat_t             out_q, out_d;
  beat_t             skid_q, skid_d;
  beat_t             in_beat;
  logic              out_valid_q, out_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              rdy_q, rdy_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              err_q, err_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic              accept;
  logic              out_free;
  logic [REP*PIX_BITS-1:0] pix_rep;
  logic [7:0]        chan;

  // Left-justify the pixel to 8 bits, filling low bits with repeated MSBs.
  assign pix_rep = {REP{in_pixel}};
  assign chan    = pix_rep[REP*PIX_BITS-1 -: 8];

  always_comb begin
    in_beat      = '0;
    in_beat.data = DATA_W'({chan, chan, chan});
    in_beat.user = in_first;
    in_beat.last = in_lastx;
  end

  assign accept   = (state_q == ST_STREAM) && rdy_q;
  assign out_free = !out_valid_q || out_stream_tready;

  // Next-state: frame-gated FSM, skid buffer, column check, frame counter.
  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    col_d        = col_q;
    err_d        = err_q;
    fcnt_d       = fcnt_q;

    case (state_q)
      ST_IDLE:   if (enable) state_d = ST_STREAM;
      ST_STREAM: if (accept && in_lastx && in_lasty && !enable) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
        if (accept) begin
          skid_d       = in_beat;
          skid_valid_d = 1'b1;
        end
      end else if (accept) begin
        out_d       = in_beat;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end

    rdy_d = !skid_valid_d;

    if (accept) begin
      if (in_lastx) begin
        if (col_q != COL_LAST) err_d = 1'b1;
        col_d = '0;
        if (in_lasty) fcnt_d = fcnt_q + FC_W'(1);
      end else if (col_q == COL_LAST) begin
        err_d = 1'b1;
        col_d = '0;
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state_q      <= ST_IDLE;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      rdy_q        <= 1'b0;
      col_q        <= '0;
      err_q        <= 1'b0;
      fcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      rdy_q        <= rdy_d;
      col_q        <= col_d;
      err_q        <= err_d;
      fcnt_q       <= fcnt_d;
    end
  end

  assign streaming         = (state_q == ST_STREAM);
  assign in_valid          = (state_q == ST_STREAM);
  assign in_ready          = rdy_q;
  assign out_stream_tdata  = out_q.data;
  assign out_stream_tuser  = out_q.user;
  assign out_stream_tlast  = out_q.last;
  assign out_stream_tvalid = out_valid_q;
  assign out_stream_tkeep  = {KEEP_W{1'b1}};
  assign frame_count       = fcnt_q;
  assign line_len_err      = err_q;

endmodule

// File: tb/tb_stream_out_packer.sv
// Bench for stream_out_packer: tiler model, queue-based reference model and directed scenarios.
module tb_stream_out_packer;

  localparam int X_SIZE = 8;
  localparam int Y_SIZE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        tready = 1'b1;
  logic [7:0]  in_pixel;
  logic        in_first, in_lastx, in_lasty;
  logic        in_valid, in_ready;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tuser, tlast, tvalid;
  logic [15:0] frame_count;
  logic        line_len_err, streaming;

  int n_err = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  stream_out_packer #(.X_SIZE(X_SIZE), .PIX_BITS(8), .DATA_W(32)) dut (
    .out_stream_aclk(clk), .periph_resetn(rst_n), .enable(enable),
    .in_pixel(in_pixel), .in_first(in_first), .in_lastx(in_lastx), .in_lasty(in_lasty),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_stream_tdata(tdata), .out_stream_tkeep(tkeep), .out_stream_tuser(tuser),
    .out_stream_tlast(tlast), .out_stream_tvalid(tvalid), .out_stream_tready(tready),
    .frame_count(frame_count), .line_len_err(line_len_err), .streaming(streaming)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Tiler model: advances x/y only on an accept; row 1 ends at column 5 when short_row is set.
  int tx = 0, ty = 0, tf = 0;
  bit short_row = 1'b0;
  bit t_acc;
  assign in_first = (tx == 0) && (ty == 0);
  assign in_lastx = (short_row && ty == 1) ? (tx == 5) : (tx == X_SIZE - 1);
  assign in_lasty = (ty == Y_SIZE - 1);
  assign in_pixel = (tx == 2 && ty == 1 && tf == 0) ? 8'hA5 : 8'(tx + 8 * ty + 37 * tf);

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx = 0; ty = 0; tf = 0; t_acc = 1'b0;
      end else begin
        t_acc = in_valid && in_ready;
      end
      @(posedge clk);
      #1;
      if (t_acc && rst_n) begin
        if (in_lastx) begin
          tx = 0;
          if (in_lasty) begin ty = 0; tf++; end
          else ty++;
        end else begin
          tx++;
        end
      end
    end
  end

  // Reference model: accepted beats queue in order; at most two are held (output + skid).
  typedef struct packed {
    logic [31:0] d;
    logic        u;
    logic        l;
  } exp_t;

  exp_t q[$];
  int   m_col, m_frames, m_edges;
  bit   m_err, m_stream;

  function automatic logic [31:0] expand(input logic [7:0] p);
    return {8'h00, p, p, p};
  endfunction

  always @(negedge clk) begin
    exp_t h;
    if (!rst_n) begin
      q.delete();
      m_col = 0; m_frames = 0; m_edges = 0; m_err = 1'b0; m_stream = 1'b0;
    end else begin
      chk("tvalid", 32'(tvalid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'((m_edges > 0) && (q.size() < 2)));
      chk("in_valid", 32'(in_valid), 32'(m_stream));
      chk("streaming", 32'(streaming), 32'(m_stream));
      chk("frame_count", 32'(frame_count), 32'(m_frames[15:0]));
      chk("line_len_err", 32'(line_len_err), 32'(m_err));
      chk("tkeep", 32'(tkeep), 32'h0000000F);
      if (tvalid && q.size() > 0) begin
        h = q[0];
        chk("tdata", tdata, h.d);
        chk("tuser", 32'(tuser), 32'(h.u));
        chk("tlast", 32'(tlast), 32'(h.l));
        if (tready) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        h.d = expand(in_pixel); h.u = in_first; h.l = in_lastx;
        q.push_back(h);
        if (in_lastx) begin
          if (m_col != X_SIZE - 1) m_err = 1'b1;
          m_col = 0;
          if (in_lasty) m_frames++;
          if (in_lasty && !enable) m_stream = 1'b0;
        end else if (m_col == X_SIZE - 1) begin
          m_err = 1'b1;
          m_col = 0;
        end else begin
          m_col++;
        end
      end else if (!m_stream && enable) begin
        m_stream = 1'b1;
      end
      m_edges++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int k;
    // Reset values
    @(negedge clk);
    chk("rst_tvalid", 32'(tvalid), 32'h0);
    chk("rst_in_valid", 32'(in_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_tkeep", 32'(tkeep), 32'hF);
    chk("rst_tdata", tdata, 32'h0);
    chk("rst_tuser_tlast", 32'({tuser, tlast}), 32'h0);
    chk("rst_frame_count", 32'(frame_count), 32'h0);
    chk("rst_err_stream", 32'({line_len_err, streaming}), 32'h0);
    repeat (2) cyc();
    #1 rst_n = 1'b1;
    repeat (2) cyc();
    enable = 1'b1;

    // First frame: 32 contiguous beats, SOF on beat 0, EOL every 8th beat
    k = 0;
    @(negedge clk);
    while (!tvalid && k < 50) begin @(negedge clk); k++; end
    chk("first_beat_seen", 32'(tvalid), 32'h1);
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      chk("f1_tvalid", 32'(tvalid), 32'h1);
      chk("f1_tuser", 32'(tuser), 32'(i == 0));
      chk("f1_tlast", 32'(tlast), 32'(i % 8 == 7));
      if (i == 3)  chk("f1_tdata_px3", tdata, 32'h00030303);
      if (i == 10) chk("f1_tdata_a5", tdata, 32'h00A5A5A5);
    end
    chk("f1_frame_count", 32'(frame_count), 32'd1);

    // Backpressure: three stalled cycles mid-line
    k = 0;
    while (!(tf == 1 && ty == 1 && tx == 3) && k < 100) begin cyc(); k++; end
    chk("bp_reached", 32'(tf == 1 && ty == 1 && tx == 3), 32'h1);
    tready = 1'b0;
    @(negedge clk);
    chk("bp_rdy_a", 32'(in_ready), 32'h1);
    chk("bp_data_a", tdata, 32'h002F2F2F);
    @(negedge clk);
    chk("bp_rdy_b", 32'(in_ready), 32'h0);
    chk("bp_data_b", tdata, 32'h002F2F2F);
    @(negedge clk);
    chk("bp_rdy_c", 32'(in_ready), 32'h0);
    chk("bp_data_c", tdata, 32'h002F2F2F);
    cyc();
    tready = 1'b1;
    @(negedge clk);
    chk("bp_rdy_d", 32'(in_ready), 32'h0);
    chk("bp_data_d", tdata, 32'h002F2F2F);
    @(negedge clk);
    chk("bp_rdy_e", 32'(in_ready), 32'h1);
    chk("bp_data_e", tdata, 32'h00303030);

    // Random tready over three frames
    k = 0;
    while (tf < 2 && k < 200) begin cyc(); k++; end
    chk("f2_frame_count", 32'(frame_count), 32'd2);
    k = 0;
    while (tf < 5 && k < 3000) begin
      tready = 1'($urandom_range(0, 1));
      cyc();
      k++;
    end
    chk("rand_reached", 32'(tf), 32'd5);
    tready = 1'b1;
    repeat (4) cyc();
    chk("rand_frame_count", 32'(frame_count), 32'd5);
    chk("rand_err", 32'(line_len_err), 32'h0);

    // Drop enable at (3,1); frame completes, then IDLE
    k = 0;
    while (!(tx == 3 && ty == 1) && k < 100) begin cyc(); k++; end
    enable = 1'b0;
    k = 0;
    while (streaming && k < 200) begin cyc(); k++; end
    chk("stop_idle", 32'(streaming), 32'h0);
    chk("stop_frame_count", 32'(frame_count), 32'd6);
    chk("stop_in_valid", 32'(in_valid), 32'h0);
    repeat (5) cyc();
    chk("idle_in_valid", 32'(in_valid), 32'h0);
    chk("idle_drained", 32'(tvalid), 32'h0);
    enable = 1'b1;
    short_row = 1'b1;
    k = 0;
    @(negedge clk);
    while (!tvalid && k < 50) begin @(negedge clk); k++; end
    chk("restart_tuser", 32'(tuser), 32'h1);
    chk("restart_tdata", tdata, 32'h00DEDEDE);

    // Short line (lastx at column 5) sets a sticky error
    cyc();
    k = 0;
    while (ty != 2 && k < 100) begin cyc(); k++; end
    short_row = 1'b0;
    cyc();
    chk("short_err_set", 32'(line_len_err), 32'h1);
    k = 0;
    while (tf < 8 && k < 300) begin cyc(); k++; end
    repeat (3) cyc();
    chk("short_err_sticky", 32'(line_len_err), 32'h1);
    chk("short_frame_count", 32'(frame_count), 32'd8);

    // Asynchronous reset with beats buffered
    k = 0;
    while (tx != 4 && k < 100) begin cyc(); k++; end
    tready = 1'b0;
    repeat (2) cyc();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 32'(tvalid), 32'h0);
    chk("arst_in_valid", 32'(in_valid), 32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'h0);
    enable = 1'b0;
    tready = 1'b1;
    repeat (2) cyc();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_fc", 32'(frame_count), 32'h0);
    chk("post_rst_err", 32'(line_len_err), 32'h0);
    chk("post_rst_stream", 32'(streaming), 32'h0);
    repeat (3) cyc();
    chk("post_rst_idle", 32'({streaming, in_valid, tvalid}), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
